// File: rtl/seven_seg_readback.sv
// seven_seg_readback: glitch-filtered two-digit 7-seg decoder with valid/ready output and countdown step check.
// Optional feature macro: SEG_BLANK_ACCEPT_EN (blank tens digit decodes as 0).
`default_nettype none

module seven_seg_readback #(
  parameter int STABLE_CYCLES = 4,
  parameter int VAL_W         = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_left,
  input  logic [6:0]       seg_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_value,
  output logic             out_step_ok,
  output logic             err_illegal,
  output logic             err_step,
  output logic             err_overrun,
  input  logic             err_clr
);

  localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {TRACK = 1'b0, SETTLED = 1'b1} state_t;

  state_t             state;
  logic [13:0]        samp;
  logic [13:0]        samp_prev;
  logic [CNT_W-1:0]   cnt;
  logic [13:0]        last_pat;
  logic [VAL_W-1:0]   last_val;
  logic               has_last;

  // Returns {legal, digit}; bits are g,f,e,d,c,b,a, active-low.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return 5'b0_0000;
    endcase
  endfunction

  logic [4:0]       dec_left;
  logic [4:0]       dec_right;
  logic [VAL_W-1:0] value;
  logic             changed;
  logic             evaluate;
  logic             new_pat;
  logic             legal;
  logic             load;
  logic             illegal_ev;
  logic             is_step;

`ifdef SEG_BLANK_ACCEPT_EN
  assign dec_left = (samp[13:7] == 7'h7F) ? {1'b1, 4'd0} : decode(samp[13:7]);
`else
  assign dec_left = decode(samp[13:7]);
`endif
  assign dec_right = decode(samp[6:0]);

  assign value      = VAL_W'(dec_left[3:0]) * VAL_W'(10) + VAL_W'(dec_right[3:0]);
  assign changed    = (samp != samp_prev);
  assign evaluate   = (state == TRACK) && !changed && (cnt == CNT_LAST);
  assign new_pat    = !has_last || (samp != last_pat);
  assign legal      = dec_left[4] && dec_right[4];
  assign load       = evaluate && new_pat && legal;
  assign illegal_ev = evaluate && new_pat && !legal;
  assign is_step    = has_last && (value == last_val - VAL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TRACK;
      samp        <= 14'h3FFF;
      samp_prev   <= 14'h3FFF;
      cnt         <= '0;
      last_pat    <= '0;
      last_val    <= '0;
      has_last    <= 1'b0;
      out_valid   <= 1'b0;
      out_value   <= '0;
      out_step_ok <= 1'b0;
      err_illegal <= 1'b0;
      err_step    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      samp      <= {seg_left, seg_right};
      samp_prev <= samp;

      if (changed)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);

      case (state)
        TRACK:   if (evaluate) state <= SETTLED;
        SETTLED: if (changed)  state <= TRACK;
        default: state <= TRACK;
      endcase

      out_valid <= load | (out_valid & ~out_ready);
      if (load) begin
        out_value   <= value;
        out_step_ok <= is_step;
        last_pat    <= samp;
        last_val    <= value;
        has_last    <= 1'b1;
      end

      // A new event outranks a simultaneous clear.
      err_illegal <= illegal_ev | (err_illegal & ~err_clr);
      err_step    <= (load && has_last && !is_step && (value != last_val))
                     | (err_step & ~err_clr);
      err_overrun <= (load && out_valid && !out_ready) | (err_overrun & ~err_clr);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_readback.sv
// Scoreboard bench for seven_seg_readback: stimulus pushes expected outputs, a monitor pops on handshake.
`default_nettype none

module tb_seven_seg_readback;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_left;
  logic [6:0] seg_right;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_value;
  logic       out_step_ok;
  logic       err_illegal;
  logic       err_step;
  logic       err_overrun;
  logic       err_clr;

  int checks = 0;
  int errors = 0;
  int q_val[$];
  int q_ok[$];

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  seven_seg_readback #(.STABLE_CYCLES(4), .VAL_W(7)) dut (
    .clk(clk), .rst(rst), .seg_left(seg_left), .seg_right(seg_right),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_step_ok(out_step_ok), .err_illegal(err_illegal), .err_step(err_step),
    .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input int tens, input int ones, input int n);
    seg_left  = pat[tens];
    seg_right = pat[ones];
    cycles(n);
  endtask

  task automatic expect_out(input int v, input int ok);
    q_val.push_back(v);
    q_ok.push_back(ok);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q_val.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got %0d expected none", out_value);
      end else begin
        int ev;
        int eo;
        ev = q_val.pop_front();
        eo = q_ok.pop_front();
        check("out_value", int'(out_value), ev);
        check("out_step_ok", int'(out_step_ok), eo);
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    out_ready = 1'b1;
    err_clr = 1'b0;
    seg_left = pat[5];
    seg_right = pat[9];
    cycles(3);
    check("rst_valid", int'(out_valid), 0);
    check("rst_value", int'(out_value), 0);
    check("rst_flags", int'({err_illegal, err_step, err_overrun, out_step_ok}), 0);

    // 59 settles: first value, latency STABLE_CYCLES+1 edges after the sampling edge
    expect_out(59, 0);
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check("latency_edges", k, 6);
    cycles(3);

    // countdown steps
    expect_out(58, 1);
    show(5, 8, 8);
    expect_out(57, 1);
    show(5, 7, 8);
    check("err_step_after_steps", int'(err_step), 0);

    // one-cycle glitch to 88, then back to 57 (already accepted)
    show(8, 8, 1);
    show(5, 7, 10);
    check("glitch_flags", int'({err_illegal, err_step, err_overrun}), 0);

    // jump 57 -> 40
    expect_out(40, 0);
    show(4, 0, 8);
    check("err_step_set", int'(err_step), 1);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("err_step_cleared", int'(err_step), 0);

    // overrun: 10 then 09 while consumer stalls
    out_ready = 1'b0;
    show(1, 0, 8);
    show(0, 9, 8);
    check("overrun_valid_held", int'(out_valid), 1);
    check("overrun_value", int'(out_value), 9);
    check("err_overrun_set", int'(err_overrun), 1);
    expect_out(9, 1);
    out_ready = 1'b1;
    cycles(2);
    check("valid_dropped", int'(out_valid), 0);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("flags_cleared", int'({err_illegal, err_step, err_overrun}), 0);

    // blank tens digit with ones = 5
`ifdef SEG_BLANK_ACCEPT_EN
    expect_out(5, 0);
`endif
    seg_left = 7'h7F;
    seg_right = pat[5];
    cycles(8);
`ifdef SEG_BLANK_ACCEPT_EN
    check("blank_err_illegal", int'(err_illegal), 0);
`else
    check("blank_err_illegal", int'(err_illegal), 1);
`endif

    // reset in the middle of a stalled handshake
    out_ready = 1'b0;
    show(3, 3, 8);
    check("stall_valid", int'(out_valid), 1);
    check("stall_value", int'(out_value), 33);
    rst = 1'b1;
    show(3, 2, 2);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_value", int'(out_value), 0);
    check("midrst_flags", int'({err_illegal, err_step, err_overrun}), 0);
    expect_out(32, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    cycles(10);

    check("queue_drained", q_val.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
